snake_head_stepper: RTL and testbench

Upstream operand stage for the two 10-bit ripple adders that compute the snake head's next X and Y pixel coordinates. It holds the current head position and the direction state, and drives the adders' A (position) and B (signed step, two's complement mod 1024) inputs. It then consumes their sums on each game tick, checks them against the playfield walls, and either commits the move or enters the dead state.

---
 rtl/snake_head_stepper.sv | 150 +++++++++++++++
 tb/tb_snake_head_stepper.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/snake_head_stepper.sv
// Snake head stepper: holds the head position and direction, drives the
// operands of two external 10-bit adders, and commits their sums on each
// game tick if the new position lies inside the playfield walls.
module snake_head_stepper #(
   parameter int unsigned STEP    = 10,
   parameter int unsigned X_MIN   = 0,
   parameter int unsigned X_MAX   = 630,
   parameter int unsigned Y_MIN   = 0,
   parameter int unsigned Y_MAX   = 470,
   parameter int unsigned X_START = 320,
   parameter int unsigned Y_START = 240
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic [9:0] sum_x,
   input  logic [9:0] sum_y,
   output logic [9:0] head_x,
   output logic [9:0] head_y,
   output logic [9:0] delta_x,
   output logic [9:0] delta_y,
   output logic [1:0] dir,
   output logic       moved,
   output logic       dead
);

   typedef enum logic [1:0] {IDLE, RUN, DEAD} stateT;

   localparam logic [1:0] DIR_RIGHT = 2'b00;
   localparam logic [1:0] DIR_LEFT  = 2'b01;
   localparam logic [1:0] DIR_UP    = 2'b10;
   localparam logic [1:0] DIR_DOWN  = 2'b11;

   localparam logic [9:0] STEP_POS = 10'(STEP);
   localparam logic [9:0] STEP_NEG = 10'(1024 - STEP);
   localparam logic [9:0] X_LO     = 10'(X_MIN);
   localparam logic [9:0] Y_LO     = 10'(Y_MIN);
   localparam logic [9:0] X_SPAN   = 10'(X_MAX - X_MIN);
   localparam logic [9:0] Y_SPAN   = 10'(Y_MAX - Y_MIN);
   localparam logic [9:0] X_HOME   = 10'(X_START);
   localparam logic [9:0] Y_HOME   = 10'(Y_START);

   stateT      state, nextState;
   logic [1:0] pendDir, nextPendDir, nextDir;
   logic [9:0] nextHeadX, nextHeadY;
   logic       nextMoved;
   logic [1:0] reqDir;
   logic       reqValid;
   logic [9:0] offX, offY;
   logic       inBounds;

   // Window check as one unsigned compare: (sum - MIN) mod 1024 <= (MAX - MIN)
   // holds exactly when MIN <= sum <= MAX, with no always-true compare at MIN=0.
   assign offX     = sum_x - X_LO;
   assign offY     = sum_y - Y_LO;
   assign inBounds = (offX <= X_SPAN) && (offY <= Y_SPAN);

   assign dead = (state == DEAD);

   // Adder B operands follow the requested direction; left/up are -STEP mod 1024.
   always_comb begin
      delta_x = '0;
      delta_y = '0;
      case (pendDir)
         DIR_RIGHT: delta_x = STEP_POS;
         DIR_LEFT:  delta_x = STEP_NEG;
         DIR_UP:    delta_y = STEP_NEG;
         DIR_DOWN:  delta_y = STEP_POS;
         default:   delta_x = STEP_POS;
      endcase
   end

   // Button priority encoder: up > down > left > right.
   always_comb begin
      reqValid = btn_up | btn_down | btn_left | btn_right;
      reqDir   = DIR_RIGHT;
      if (btn_up)         reqDir = DIR_UP;
      else if (btn_down)  reqDir = DIR_DOWN;
      else if (btn_left)  reqDir = DIR_LEFT;
   end

   // Next-state and datapath decisions for the IDLE/RUN/DEAD controller.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      nextState   = state;
      nextHeadX   = head_x;
      nextHeadY   = head_y;
      nextDir     = dir;
      nextPendDir = pendDir;
      nextMoved   = 1'b0;
      case (state)
         IDLE: begin
            if (start) nextState = RUN;
         end
         RUN: begin
            // Reversal is judged against the committed direction; the two
            // directions of an axis differ only in bit 0.
            if (reqValid && (reqDir != (dir ^ 2'b01))) nextPendDir = reqDir;
            if (tick) begin
               nextDir = pendDir;
               if (inBounds) begin
                  nextHeadX = sum_x;
                  nextHeadY = sum_y;
                  nextMoved = 1'b1;
               end else begin
                  nextState = DEAD;
               end
            end
         end
         DEAD: begin
            if (start) begin
               nextState   = IDLE;
               nextHeadX   = X_HOME;
               nextHeadY   = Y_HOME;
               nextDir     = DIR_RIGHT;
               nextPendDir = DIR_RIGHT;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge.
      if (rst) begin
         state   <= IDLE;
         head_x  <= X_HOME;
         head_y  <= Y_HOME;
         dir     <= DIR_RIGHT;
         pendDir <= DIR_RIGHT;
         moved   <= 1'b0;
      end else begin
         state   <= nextState;
         head_x  <= nextHeadX;
         head_y  <= nextHeadY;
         dir     <= nextDir;
         pendDir <= nextPendDir;
         moved   <= nextMoved;
      end
   end

endmodule

// File: tb/tb_snake_head_stepper.sv
// Testbench for snake_head_stepper: table of single-cycle vectors followed by
// hand-written wall-collision, restart and mid-game reset sequences.
module tb_snake_head_stepper;

   logic       clk = 1'b0;
   logic       rst, tick, start;
   logic       btn_up, btn_down, btn_left, btn_right;
   logic [9:0] sum_x, sum_y;
   logic [9:0] head_x, head_y, delta_x, delta_y;
   logic [1:0] dir;
   logic       moved, dead;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // The two external ripple adders (carry-out dropped, mod 1024).
   assign sum_x = head_x + delta_x;
   assign sum_y = head_y + delta_y;

   snake_head_stepper dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .sum_x(sum_x), .sum_y(sum_y),
      .head_x(head_x), .head_y(head_y), .delta_x(delta_x), .delta_y(delta_y),
      .dir(dir), .moved(moved), .dead(dead)
   );

   typedef struct {
      logic       r, s, t;
      logic [3:0] b;       // {up, down, left, right}
      logic [9:0] hx, hy;
      logic [1:0] d;
      logic       mv, dd;
      logic [9:0] dx, dy;
   } vecT;

   vecT vecs[19];

   task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
      end
   endtask

   // Drive inputs, let one rising edge pass, sample 1 time unit later.
   task automatic step(input logic r, input logic s, input logic t, input logic [3:0] b);
      rst = r; start = s; tick = t;
      {btn_up, btn_down, btn_left, btn_right} = b;
      @(posedge clk);
      #1;
   endtask

   task automatic checkPos(input string tag, input logic [9:0] hx, input logic [9:0] hy,
                           input logic [1:0] d, input logic mv, input logic dd);
      check({tag, " head_x"}, head_x, hx);
      check({tag, " head_y"}, head_y, hy);
      check({tag, " dir"}, 10'(dir), 10'(d));
      check({tag, " moved"}, 10'(moved), 10'(mv));
      check({tag, " dead"}, 10'(dead), 10'(dd));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; tick = 1'b0;
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;

      //         r     s     t     b        hx   hy   d      mv    dd    dx      dy
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 320, 240, 2'd0, 1'b0, 1'b0, 10'h00A, 10'h000};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'b1000, 320, 240, 2'd0, 1'b0, 1'b0, 10'h00A, 10'h000}; // IDLE ignores
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 4'b0000, 320, 240, 2'd0, 1'b0, 1'b0, 10'h00A, 10'h000}; // start+tick
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 330, 240, 2'd0, 1'b1, 1'b0, 10'h00A, 10'h000};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 330, 240, 2'd0, 1'b0, 1'b0, 10'h00A, 10'h000};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'b0010, 330, 240, 2'd0, 1'b0, 1'b0, 10'h00A, 10'h000}; // reverse
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'b0010, 340, 240, 2'd0, 1'b1, 1'b0, 10'h00A, 10'h000};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'b1000, 340, 240, 2'd0, 1'b0, 1'b0, 10'h000, 10'h3F6}; // up
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'b0010, 340, 240, 2'd0, 1'b0, 1'b0, 10'h000, 10'h3F6}; // left vs dir
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 340, 230, 2'd2, 1'b1, 1'b0, 10'h000, 10'h3F6};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 4'b0011, 340, 230, 2'd2, 1'b0, 1'b0, 10'h3F6, 10'h000}; // left>right
      vecs[11] = '{1'b0, 1'b0, 1'b0, 4'b1010, 340, 230, 2'd2, 1'b0, 1'b0, 10'h000, 10'h3F6}; // up>left
      vecs[12] = '{1'b0, 1'b0, 1'b0, 4'b0110, 340, 230, 2'd2, 1'b0, 1'b0, 10'h000, 10'h3F6}; // down rev
      vecs[13] = '{1'b0, 1'b0, 1'b0, 4'b0001, 340, 230, 2'd2, 1'b0, 1'b0, 10'h00A, 10'h000};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 4'b0010, 350, 230, 2'd0, 1'b1, 1'b0, 10'h3F6, 10'h000}; // press+tick
      vecs[15] = '{1'b0, 1'b0, 1'b0, 4'b0000, 350, 230, 2'd0, 1'b0, 1'b0, 10'h3F6, 10'h000};
      vecs[16] = '{1'b0, 1'b0, 1'b1, 4'b0000, 340, 230, 2'd1, 1'b1, 1'b0, 10'h3F6, 10'h000};
      vecs[17] = '{1'b1, 1'b0, 1'b1, 4'b0000, 320, 240, 2'd0, 1'b0, 1'b0, 10'h00A, 10'h000}; // reset
      vecs[18] = '{1'b0, 1'b0, 1'b1, 4'b0000, 320, 240, 2'd0, 1'b0, 1'b0, 10'h00A, 10'h000}; // IDLE

      for (int i = 0; i < 19; i++) begin
         step(vecs[i].r, vecs[i].s, vecs[i].t, vecs[i].b);
         checkPos($sformatf("row%0d", i), vecs[i].hx, vecs[i].hy, vecs[i].d, vecs[i].mv, vecs[i].dd);
         check($sformatf("row%0d delta_x", i), delta_x, vecs[i].dx);
         check($sformatf("row%0d delta_y", i), delta_y, vecs[i].dy);
      end

      // Right wall: 630 is still legal, 640 is not.
      step(1'b0, 1'b1, 1'b0, 4'b0000);
      for (int i = 0; i < 31; i++) step(1'b0, 1'b0, 1'b1, 4'b0000);
      checkPos("xmax reached", 630, 240, 2'd0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 4'b0000);
      checkPos("xmax crash", 630, 240, 2'd0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 4'b0000);
      checkPos("xmax restart", 320, 240, 2'd0, 1'b0, 1'b0);

      // Left wall: x=0 is legal, the next step wraps to 1014 and kills.
      step(1'b0, 1'b1, 1'b0, 4'b0000);
      step(1'b0, 1'b0, 1'b0, 4'b1000);
      step(1'b0, 1'b0, 1'b1, 4'b0000);
      checkPos("turn up", 320, 230, 2'd2, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 4'b0010);
      step(1'b0, 1'b0, 1'b1, 4'b0000);
      checkPos("turn left", 310, 230, 2'd1, 1'b1, 1'b0);
      for (int i = 0; i < 31; i++) step(1'b0, 1'b0, 1'b1, 4'b0000);
      checkPos("xmin reached", 0, 230, 2'd1, 1'b1, 1'b0);
      check("xmin sum_x", sum_x, 10'h3F6);
      step(1'b0, 1'b0, 1'b1, 4'b0000);
      checkPos("xmin crash", 0, 230, 2'd1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 4'b1001);
      checkPos("dead holds", 0, 230, 2'd1, 1'b0, 1'b1);
      check("dead ignores btn", delta_x, 10'h3F6);
      step(1'b0, 1'b1, 1'b0, 4'b0000);
      checkPos("dead restart", 320, 240, 2'd0, 1'b0, 1'b0);
      check("restart delta_x", delta_x, 10'h00A);
      step(1'b0, 1'b0, 1'b1, 4'b0000);
      checkPos("idle after restart", 320, 240, 2'd0, 1'b0, 1'b0);

      // Bottom wall: 470 is legal, 480 is not.
      step(1'b0, 1'b1, 1'b0, 4'b0100);
      step(1'b0, 1'b0, 1'b0, 4'b0100);
      for (int i = 0; i < 23; i++) step(1'b0, 1'b0, 1'b1, 4'b0000);
      checkPos("ymax reached", 320, 470, 2'd3, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 4'b0000);
      checkPos("ymax crash", 320, 470, 2'd3, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 4'b0000);

      // Reset in the middle of a run at (400,100) with down pending.
      step(1'b0, 1'b1, 1'b0, 4'b0000);
      step(1'b0, 1'b0, 1'b0, 4'b1000);
      for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b1, 4'b0000);
      step(1'b0, 1'b0, 1'b0, 4'b0001);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 4'b0000);
      checkPos("at 400,100", 400, 100, 2'd0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 4'b0100);
      check("pend down delta_y", delta_y, 10'h00A);
      step(1'b1, 1'b0, 1'b1, 4'b0000);
      checkPos("mid reset", 320, 240, 2'd0, 1'b0, 1'b0);
      check("mid reset delta_x", delta_x, 10'h00A);
      check("mid reset delta_y", delta_y, 10'h000);
      step(1'b0, 1'b0, 1'b1, 4'b0000);
      checkPos("idle after reset", 320, 240, 2'd0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
